uart_rx_buf: RTL and testbench

//  Synthesizable, parametrised serial receiver with a receive FIFO; successor to the SoC's

---
 rtl/uart_rx_pkg.sv | 28 ++
 rtl/uart_rx_fifo.sv | 55 +++++
 rtl/uart_rx_buf.sv | 176 +++++++++++++++++
 tb/tb_uart_rx_buf.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the uart_rx_buf serial receiver.
package uart_rx_pkg;

  localparam int unsigned DIV_RST_DEFAULT = 106;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // Receive FIFO entry at the widest legal frame (9 data bits).
  typedef struct packed {
    logic       perr;
    logic       ferr;
    logic [8:0] data;
  } rx_entry_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Single-clock receive FIFO with occupancy count; pop when empty is ignored,
// push when full is accepted only alongside a pop.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [clog2(DEPTH):0] level
);

  localparam int unsigned AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head is forced to zero while empty so the outputs read 0 out of reset.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_buf.sv
// Parametrised serial receiver (mid-bit sampling, LSB first) feeding a receive FIFO.
// Optional parity bit and parity_odd port when UART_RX_PARITY_EN is defined.
module uart_rx_buf
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned DIV_RST    = DIV_RST_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ser_rx,
  input  logic [DIV_W-1:0]           cfg_div,
  output logic [DATA_BITS-1:0]       rx_data,
  output logic                       rx_ferr,
  output logic                       rx_perr,
  output logic                       rx_valid,
  input  logic                       rx_ready,
`ifdef UART_RX_PARITY_EN
  input  logic                       parity_odd,
`endif
  output logic [clog2(FIFO_DEPTH):0] rx_level,
  output logic                       ovr,
  input  logic                       ovr_clr,
  output logic                       busy
);

  localparam int unsigned EW = DATA_BITS + 2;

  rx_state_t            state;
  logic                 rx_meta;
  logic                 rx_sync;
  logic                 rx_prev;
  logic                 fall;
  logic [DIV_W-1:0]     div_eff;
  logic [DIV_W-1:0]     div_q;
  logic [DIV_W-1:0]     cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 perr_bit;
  logic                 push;
  logic                 drop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [EW-1:0]        wr_entry;
  logic [EW-1:0]        head;

  // Presetting to 1 keeps reset release from looking like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= ser_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign fall = rx_prev && !rx_sync;

  always_comb begin
    div_eff = cfg_div;
    if (cfg_div == '0)
      div_eff = DIV_W'(DIV_RST);
    else if (cfg_div == DIV_W'(1))
      div_eff = DIV_W'(2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      div_q   <= '0;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
`ifdef UART_RX_PARITY_EN
      perr_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (fall) begin
          div_q <= div_eff;
          cnt   <= (div_eff >> 1) - 1'b1;
          busy  <= 1'b1;
          state <= START;
        end
        START: if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else if (!rx_sync) begin
          cnt     <= div_q - 1'b1;
          bit_cnt <= '0;
          state   <= DATA;
        end else begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        DATA: if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          shift <= {rx_sync, shift[DATA_BITS-1:1]};
          cnt   <= div_q - 1'b1;
          if (bit_cnt == 4'(DATA_BITS - 1))
`ifdef UART_RX_PARITY_EN
            state <= PARITY;
`else
            state <= STOP;
`endif
          else
            bit_cnt <= bit_cnt + 1'b1;
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          perr_bit <= (^shift) ^ rx_sync ^ parity_odd;
          cnt      <= div_q - 1'b1;
          state    <= STOP;
        end
`endif
        STOP: if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign perr_bit = 1'b0;
`endif

  // The word is pushed on the stop-sample cycle itself, not a cycle later.
  assign push     = (state == STOP) && (cnt == '0);
  assign wr_entry = {perr_bit, ~rx_sync, shift};
  assign drop     = push && fifo_full && !rx_ready;

  uart_rx_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (wr_entry),
    .pop     (rx_ready),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (rx_level)
  );

  assign rx_valid = !fifo_empty;
  assign rx_data  = head[DATA_BITS-1:0];
  assign rx_ferr  = head[DATA_BITS];
  assign rx_perr  = head[DATA_BITS+1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ovr <= 1'b0;
    else if (drop)
      ovr <= 1'b1;
    else if (ovr_clr)
      ovr <= 1'b0;
  end

endmodule

// File: tb/tb_uart_rx_buf.sv
// Self-checking bench for uart_rx_buf: vector table, directed corner cases and
// randomized frames checked against a queue model of the receive path.
module tb_uart_rx_buf;

  logic        clk = 1'b0;
  logic        reset;
  logic        ser_rx;
  logic [15:0] cfg_div;
  logic [7:0]  rx_data;
  logic        rx_ferr;
  logic        rx_perr;
  logic        rx_valid;
  logic        rx_ready;
  logic [4:0]  rx_level;
  logic        ovr;
  logic        ovr_clr;
  logic        busy;
`ifdef UART_RX_PARITY_EN
  logic        parity_odd;
  int          par_force = 0; // 0: correct parity, 1: force 0, 2: force 1
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_rx_buf #(
    .DATA_BITS  (8),
    .FIFO_DEPTH (16),
    .DIV_W      (16),
    .DIV_RST    (106)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ser_rx     (ser_rx),
    .cfg_div    (cfg_div),
    .rx_data    (rx_data),
    .rx_ferr    (rx_ferr),
    .rx_perr    (rx_perr),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
`ifdef UART_RX_PARITY_EN
    .parity_odd (parity_odd),
`endif
    .rx_level   (rx_level),
    .ovr        (ovr),
    .ovr_clr    (ovr_clr),
    .busy       (busy)
  );

  typedef struct {
    logic [15:0] cfg;
    int          div;
    logic [7:0]  d;
    logic        stop;
    logic [7:0]  exp_d;
    logic        exp_ferr;
  } vec_t;

  vec_t       tbl[8];
  logic [8:0] mq[$];
  bit         rnd_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame bit-serially, then idles long enough for the push to land.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int div);
    logic [11:0] bits;
    int          n;
    bits    = '1;
    n       = 0;
    bits[n] = 1'b0;
    n++;
    for (int i = 0; i < 8; i++) begin
      bits[n] = d[i];
      n++;
    end
`ifdef UART_RX_PARITY_EN
    bits[n] = (par_force == 0) ? ((^d) ^ parity_odd) : (par_force == 2);
    n++;
`endif
    bits[n] = stop_bit;
    n++;
    for (int i = 0; i < n; i++) begin
      ser_rx = bits[i];
      tick(div);
    end
    ser_rx = 1'b1;
    tick(div + 4);
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int c;
    logic [8:0] exp;

    tbl[0] = '{16'd106, 106, 8'hA5, 1'b0, 8'hA5, 1'b1};
    tbl[1] = '{16'd106, 106, 8'h3C, 1'b1, 8'h3C, 1'b0};
    tbl[2] = '{16'd0,   106, 8'hC3, 1'b1, 8'hC3, 1'b0};
    tbl[3] = '{16'd16,  16,  8'h00, 1'b1, 8'h00, 1'b0};
    tbl[4] = '{16'd16,  16,  8'hFF, 1'b1, 8'hFF, 1'b0};
    tbl[5] = '{16'd1,   2,   8'h81, 1'b1, 8'h81, 1'b0};
    tbl[6] = '{16'd2,   2,   8'h7E, 1'b0, 8'h7E, 1'b1};
    tbl[7] = '{16'd23,  23,  8'h5A, 1'b1, 8'h5A, 1'b0};

    reset    = 1'b1;
    ser_rx   = 1'b1;
    rx_ready = 1'b0;
    ovr_clr  = 1'b0;
    cfg_div  = 16'd106;
`ifdef UART_RX_PARITY_EN
    parity_odd = 1'b0;
`endif
    tick(3);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_ferr", rx_ferr, 0);
    check("rst_rx_perr", rx_perr, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_level", rx_level, 0);
    check("rst_ovr", ovr, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    tick(5);

    // First frame latency from the start edge.
    lat = 0;
    fork
      send_frame(8'h55, 1'b1, 106);
      begin
        while (rx_valid !== 1'b1 && lat < 1200) begin
          tick(1);
          lat++;
        end
      end
    join
    check("latency_within_bound", (lat <= 10 * 106 + 4), 1);
    check("latency_data", rx_data, 8'h55);
    check("latency_ferr", rx_ferr, 0);
    check("latency_level", rx_level, 1);
    pop_one();
    check("latency_popped", rx_valid, 0);

    for (int i = 0; i < 8; i++) begin
      cfg_div = tbl[i].cfg;
      send_frame(tbl[i].d, tbl[i].stop, tbl[i].div);
      check($sformatf("tbl%0d_valid", i), rx_valid, 1);
      check($sformatf("tbl%0d_data", i), rx_data, tbl[i].exp_d);
      check($sformatf("tbl%0d_ferr", i), rx_ferr, tbl[i].exp_ferr);
      check($sformatf("tbl%0d_perr", i), rx_perr, 0);
      pop_one();
      check($sformatf("tbl%0d_empty", i), rx_valid, 0);
    end

    // Fill to depth, then one more word overruns.
    cfg_div = 16'd16;
    for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1, 16);
    check("fill_level", rx_level, 16);
    check("fill_ovr", ovr, 0);
    send_frame(8'h10, 1'b1, 16);
    check("ovr_set", ovr, 1);
    check("ovr_level", rx_level, 16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("ovr_pop%0d", i), rx_data, 32'(i));
      pop_one();
    end
    check("ovr_drained", rx_valid, 0);
    check("ovr_sticky", ovr, 1);
    ovr_clr = 1'b1;
    tick(1);
    ovr_clr = 1'b0;
    check("ovr_cleared", ovr, 0);

    // Short low glitch on the idle line must be rejected at the start sample.
    cfg_div = 16'd106;
    ser_rx  = 1'b0;
    tick(40);
    ser_rx = 1'b1;
    check("glitch_busy", busy, 1);
    c = 0;
    while (busy !== 1'b0 && c < 200) begin
      tick(1);
      c++;
    end
    check("glitch_busy_drop", busy, 0);
    check("glitch_drop_time", (c <= 30), 1);
    tick(20);
    check("glitch_no_push", rx_level, 0);

    // Divider change during a frame applies only to the next frame.
    cfg_div = 16'd106;
    fork
      send_frame(8'hC3, 1'b1, 106);
      begin
        tick(300);
        cfg_div = 16'd54;
      end
    join
    check("divchg_cur_data", rx_data, 8'hC3);
    check("divchg_cur_ferr", rx_ferr, 0);
    pop_one();
    send_frame(8'h96, 1'b1, 54);
    check("divchg_next_data", rx_data, 8'h96);
    check("divchg_next_ferr", rx_ferr, 0);
    pop_one();

`ifdef UART_RX_PARITY_EN
    cfg_div    = 16'd16;
    parity_odd = 1'b0;
    par_force  = 1;
    send_frame(8'h07, 1'b1, 16);
    check("par_bad_data", rx_data, 8'h07);
    check("par_bad_perr", rx_perr, 1);
    pop_one();
    par_force = 2;
    send_frame(8'h07, 1'b1, 16);
    check("par_good_perr", rx_perr, 0);
    pop_one();
    par_force  = 0;
    parity_odd = 1'b1;
    send_frame(8'h07, 1'b1, 16);
    check("par_odd_perr", rx_perr, 0);
    pop_one();
    parity_odd = 1'b0;
`endif

    // Randomized frames against a queue model with a random-ready consumer.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          logic [7:0]  d;
          logic        sb;
          logic [15:0] dv;
          d       = 8'($urandom);
          sb      = ($urandom_range(0, 7) != 0);
          dv      = 16'($urandom_range(2, 24));
          cfg_div = dv;
          mq.push_back({~sb, d});
          send_frame(d, sb, int'(dv));
        end
        c = 0;
        while (mq.size() != 0 && c < 400) begin
          tick(1);
          c++;
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(negedge clk);
          rx_ready = ($urandom_range(0, 1) == 1);
          if (rx_valid && rx_ready) begin
            if (mq.size() == 0) begin
              check("rnd_spurious", rx_valid, 0);
            end else begin
              exp = mq.pop_front();
              check("rnd_word", {rx_ferr, rx_data}, exp);
            end
          end
        end
        rx_ready = 1'b0;
      end
    join
    tick(2);
    check("rnd_model_drained", mq.size(), 0);
    check("rnd_fifo_empty", rx_valid, 0);
    check("rnd_no_ovr", ovr, 0);

    // Reset in the middle of a frame flushes the FIFO and the receiver.
    cfg_div = 16'd16;
    send_frame(8'h11, 1'b1, 16);
    check("mid_rst_pre_level", rx_level, 1);
    cfg_div = 16'd106;
    ser_rx  = 1'b0;
    tick(300);
    check("mid_rst_busy_pre", busy, 1);
    reset  = 1'b1;
    ser_rx = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(5);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_level", rx_level, 0);
    check("mid_rst_valid", rx_valid, 0);
    check("mid_rst_ovr", ovr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
